// File: rtl/sram_pkg.sv
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared types and constants for the two-port SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

  localparam int SRAM_ADDR_W    = 7;
  localparam int SRAM_DEPTH     = 128;
  localparam int BYTES_PER_WORD = 4;
  localparam int SRAM_DATA_W    = 32;

  // Sequencer states: one request in flight, no overlap.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Requester identity; also the encoding of the last-grant register.
  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  // Request as seen at the accept point, after port selection.
  typedef struct packed {
    logic [31:0]               addr;
    logic                      we;
    logic [BYTES_PER_WORD-1:0] wmask;
    logic [SRAM_DATA_W-1:0]    wdata;
  } req_t;

endpackage

`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
// ============================================================================
// Module   : sram_rr_arbiter
// Purpose  : Two-way round-robin grant. Grants are combinational; the
//            last-grant register only advances on an accepted request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_rr_arbiter
  import sram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,          // grants only issued while the sequencer is idle
  input  logic req_fetch_i,
  input  logic req_data_i,
  input  logic accept_i,      // a grant was taken this cycle
  output logic gnt_fetch_o,
  output logic gnt_data_o
);

  port_e last_grant_q;
  port_e last_grant_d;

  // Grant selection: a lone requester wins; on contention the port that
  // did not win last time goes first.
  always_comb begin
    gnt_fetch_o = 1'b0;
    gnt_data_o  = 1'b0;
    if (en_i) begin
      if (req_fetch_i && req_data_i) begin
        if (last_grant_q == PORT_FETCH) begin
          gnt_data_o = 1'b1;
        end else begin
          gnt_fetch_o = 1'b1;
        end
      end else begin
        gnt_fetch_o = req_fetch_i;
        gnt_data_o  = req_data_i;
      end
    end
  end

  // Next last-grant value: follows whichever port was actually accepted.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_i) begin
      last_grant_d = gnt_data_o ? PORT_DATA : PORT_FETCH;
    end
  end

  // Last-grant register; reset makes data the first winner on contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_FETCH;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Shares a pulse-triggered, byte-maskable SRAM between the fetch
//            (read-only) and data ports. Each accepted request walks
//            IDLE -> SETUP -> PULSE -> RESP and answers three cycles later.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter
  import sram_pkg::*;
#(
  parameter int          ADDR_W    = SRAM_ADDR_W,
  parameter int          DATA_W    = SRAM_DATA_W,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  // fetch port
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [31:0]         if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_rdata,
  output logic                if_rsp_err,
  // data port
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [31:0]         d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W/8-1:0] d_req_wmask,
  input  logic [DATA_W-1:0]   d_req_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_rdata,
  output logic                d_rsp_err,
  // SRAM macro
  output logic [ADDR_W-1:0]   sram_addr_sel,
  output logic [DATA_W/8-1:0] sram_byte_sel,
  output logic                sram_read_pulse,
  output logic                sram_write_pulse,
  output logic [DATA_W-1:0]   sram_datain,
  input  logic [DATA_W-1:0]   sram_dataout,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  state_e              state_q;
  state_e              state_d;

  logic                w_gnt_fetch;
  logic                w_gnt_data;
  logic                w_accept;
  req_t                w_req;
  logic [30:0]         w_word_diff;
  logic                w_fault;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_do_pulse;
  logic                w_rd_ok;

  port_e               port_q;
  logic                fault_q;
  logic                we_q;
  logic [BE_W-1:0]     wmask_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     bsel_q;
  logic [DATA_W-1:0]   datain_q;

  sram_rr_arbiter u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q == IDLE),
    .req_fetch_i (if_req_valid),
    .req_data_i  (d_req_valid),
    .accept_i    (w_accept),
    .gnt_fetch_o (w_gnt_fetch),
    .gnt_data_o  (w_gnt_data)
  );

  // A grant already implies the granted port is valid, so grant == accept.
  assign if_req_ready = w_gnt_fetch;
  assign d_req_ready  = w_gnt_data;
  assign w_accept     = w_gnt_fetch | w_gnt_data;

  // Present the granted port's request in a common shape; fetch never writes.
  always_comb begin
    w_req = '0;
    if (w_gnt_data) begin
      w_req.addr  = d_req_addr;
      w_req.we    = d_req_we;
      w_req.wmask = d_req_wmask;
      w_req.wdata = d_req_wdata;
    end else begin
      w_req.addr  = if_req_addr;
    end
  end

  // Word offset from the base. Working on word addresses keeps the borrow
  // bit as the below-base flag and leaves the upper bits as the range check.
  assign w_word_diff = {1'b0, w_req.addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
  assign w_fault     = (|w_req.addr[1:0]) | w_word_diff[30] | (|w_word_diff[29:ADDR_W]);
  assign w_idx       = w_word_diff[ADDR_W-1:0];

  // Request capture on accept. The SRAM bus only moves for good requests so
  // a faulted access never disturbs the macro inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q   <= PORT_FETCH;
      fault_q  <= 1'b0;
      we_q     <= 1'b0;
      wmask_q  <= '0;
      addr_q   <= '0;
      bsel_q   <= '0;
      datain_q <= '0;
    end else if (w_accept) begin
      port_q  <= w_gnt_data ? PORT_DATA : PORT_FETCH;
      fault_q <= w_fault;
      we_q    <= w_req.we;
      wmask_q <= w_req.wmask;
      if (!w_fault) begin
        addr_q   <= w_idx;
        bsel_q   <= w_req.we ? w_req.wmask : {BE_W{1'b1}};
        datain_q <= w_req.wdata;
      end
    end
  end

  assign sram_addr_sel = addr_q;
  assign sram_byte_sel = bsel_q;
  assign sram_datain   = datain_q;
  assign busy          = (state_q != IDLE);

  // A zero-mask write is legal but has nothing to store, so it skips the pulse.
  assign w_do_pulse = !fault_q && (!we_q || (|wmask_q));
  assign w_rd_ok    = !fault_q && !we_q;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs; pulses and responses come straight
  // from the state so an asynchronous reset removes them at once.
  always_comb begin
    state_d          = state_q;
    sram_read_pulse  = 1'b0;
    sram_write_pulse = 1'b0;
    if_rsp_valid     = 1'b0;
    if_rsp_rdata     = '0;
    if_rsp_err       = 1'b0;
    d_rsp_valid      = 1'b0;
    d_rsp_rdata      = '0;
    d_rsp_err        = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = PULSE;
      end
      PULSE: begin
        sram_read_pulse  = w_do_pulse && !we_q;
        sram_write_pulse = w_do_pulse && we_q;
        state_d          = RESP;
      end
      RESP: begin
        if (port_q == PORT_DATA) begin
          d_rsp_valid = 1'b1;
          d_rsp_err   = fault_q;
          d_rsp_rdata = w_rd_ok ? sram_dataout : '0;
        end else begin
          if_rsp_valid = 1'b1;
          if_rsp_err   = fault_q;
          if_rsp_rdata = w_rd_ok ? sram_dataout : '0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Directed self-checking bench for sram_arbiter with a behavioural
//            pulse-triggered SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_rdata;
  logic        if_rsp_err;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [3:0]  d_req_wmask;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        d_rsp_err;
  logic [6:0]  sram_addr_sel;
  logic [3:0]  sram_byte_sel;
  logic        sram_read_pulse;
  logic        sram_write_pulse;
  logic [31:0] sram_datain;
  logic [31:0] sram_dataout;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // SRAM model state and pulse observation
  logic [31:0] mem [128];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [6:0]  p_addr = '0;
  logic [3:0]  p_bsel = '0;

  sram_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_req_valid     (if_req_valid),
    .if_req_ready     (if_req_ready),
    .if_req_addr      (if_req_addr),
    .if_rsp_valid     (if_rsp_valid),
    .if_rsp_rdata     (if_rsp_rdata),
    .if_rsp_err       (if_rsp_err),
    .d_req_valid      (d_req_valid),
    .d_req_ready      (d_req_ready),
    .d_req_addr       (d_req_addr),
    .d_req_we         (d_req_we),
    .d_req_wmask      (d_req_wmask),
    .d_req_wdata      (d_req_wdata),
    .d_rsp_valid      (d_rsp_valid),
    .d_rsp_rdata      (d_rsp_rdata),
    .d_rsp_err        (d_rsp_err),
    .sram_addr_sel    (sram_addr_sel),
    .sram_byte_sel    (sram_byte_sel),
    .sram_read_pulse  (sram_read_pulse),
    .sram_write_pulse (sram_write_pulse),
    .sram_datain      (sram_datain),
    .sram_dataout     (sram_dataout),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse-triggered SRAM: a pulse high at a rising edge performs the access.
  initial sram_dataout = '0;
  always @(posedge clk) begin
    if (sram_write_pulse) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_byte_sel[b]) mem[sram_addr_sel][8*b +: 8] = sram_datain[8*b +: 8];
      end
      wr_cnt = wr_cnt + 1;
      p_addr = sram_addr_sel;
      p_bsel = sram_byte_sel;
    end
    if (sram_read_pulse) begin
      sram_dataout <= mem[sram_addr_sel];
      rd_cnt = rd_cnt + 1;
      p_addr = sram_addr_sel;
      p_bsel = sram_byte_sel;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated request: accept at N, response checked at N+3, idle at N+4.
  task automatic txn(input string tag, input bit is_d, input logic [31:0] a,
                     input bit we, input logic [3:0] m, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input bit exp_err, input bit exp_pulse,
                     input logic [6:0] exp_idx, input logic [3:0] exp_bs);
    int rd0;
    int wr0;
    @(negedge clk);
    if (is_d) begin
      d_req_valid = 1'b1; d_req_addr = a; d_req_we = we; d_req_wmask = m; d_req_wdata = wd;
    end else begin
      if_req_valid = 1'b1; if_req_addr = a;
    end
    #1;
    check({tag, ":ready"}, {30'd0, if_req_ready, d_req_ready}, is_d ? 32'd1 : 32'd2);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    #1;
    check({tag, ":setup_busy_ready"}, {29'd0, busy, if_req_ready, d_req_ready}, 32'd4);
    @(negedge clk);
    @(negedge clk);
    #1;
    check({tag, ":rsp_valid"}, {30'd0, if_rsp_valid, d_rsp_valid}, is_d ? 32'd1 : 32'd2);
    check({tag, ":rdata"}, is_d ? d_rsp_rdata : if_rsp_rdata, exp_rd);
    check({tag, ":err"}, {31'd0, is_d ? d_rsp_err : if_rsp_err}, {31'd0, exp_err});
    check({tag, ":rd_pulses"}, rd_cnt - rd0, (exp_pulse && !we) ? 32'd1 : 32'd0);
    check({tag, ":wr_pulses"}, wr_cnt - wr0, (exp_pulse && we) ? 32'd1 : 32'd0);
    if (exp_pulse) begin
      check({tag, ":pulse_addr"}, {25'd0, p_addr}, {25'd0, exp_idx});
      check({tag, ":pulse_bsel"}, {28'd0, p_bsel}, {28'd0, exp_bs});
    end
    @(negedge clk);
    #1;
    check({tag, ":back_idle"}, {29'd0, busy, if_rsp_valid, d_rsp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;
    mem[5]  = 32'h12345678;
    mem[12] = 32'hA5A5A5A5;
    rst_n        = 1'b0;
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    d_req_valid  = 1'b0;
    d_req_addr   = '0;
    d_req_we     = 1'b0;
    d_req_wmask  = '0;
    d_req_wdata  = '0;

    // Reset state
    #2;
    check("rst:ctrl", {25'd0, if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid,
                       sram_read_pulse, sram_write_pulse, busy}, 32'd0);
    check("rst:rsp_data", if_rsp_rdata | d_rsp_rdata | {30'd0, if_rsp_err, d_rsp_err}, 32'd0);
    check("rst:sram_bus", sram_datain | {21'd0, sram_addr_sel, sram_byte_sel}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention straight after reset: data, fetch, data, fetch, 4 cycles apart.
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid  = 1'b1; d_req_addr  = 32'h14; d_req_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr%0d:grant", k), {30'd0, if_req_ready, d_req_ready},
            (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      #1;
      check($sformatf("rr%0d:ready_busy", k), {30'd0, if_req_ready, d_req_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1;
      check($sformatf("rr%0d:rsp_valid", k), {30'd0, if_rsp_valid, d_rsp_valid},
            (k % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr%0d:rdata", k), (k % 2 == 0) ? d_rsp_rdata : if_rsp_rdata,
            (k % 2 == 0) ? 32'h12345678 : 32'hDEADBEEF);
      @(negedge clk);
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;

    // Basic read, partial write, read-back, faults, zero-mask write
    txn("fetch_rd", 1'b0, 32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 7'd4, 4'hF);
    txn("d_wr_mask", 1'b1, 32'h2C, 1'b1, 4'b0011, 32'hFACEB00C, 32'h0, 1'b0, 1'b1, 7'd11, 4'b0011);
    txn("d_rd_back", 1'b1, 32'h2C, 1'b0, 4'h0, 32'h0, 32'h0000B00C, 1'b0, 1'b1, 7'd11, 4'hF);
    txn("d_misalign", 1'b1, 32'h201, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 7'd0, 4'h0);
    txn("f_range", 1'b0, 32'h200, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 7'd0, 4'h0);
    txn("d_wr_zero", 1'b1, 32'h2C, 1'b1, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 7'd0, 4'h0);
    txn("d_rd_keep", 1'b1, 32'h2C, 1'b0, 4'h0, 32'h0, 32'h0000B00C, 1'b0, 1'b1, 7'd11, 4'hF);
    txn("f_rd_last", 1'b0, 32'h1FC, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 7'd127, 4'hF);

    // Reset during PULSE: strobe drops immediately, nothing is written or answered.
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = 32'h30; d_req_we = 1'b1;
    d_req_wmask = 4'hF; d_req_wdata = 32'h11111111;
    @(negedge clk);
    d_req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst:pulse_before", {31'd0, sram_write_pulse}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst:pulse_after", {30'd0, sram_write_pulse, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("mid_rst:quiet%0d", c),
            {28'd0, if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid}, 32'd0);
      @(negedge clk);
    end
    check("mid_rst:no_write", wr_cnt, 32'd1);
    txn("post_rst_rd", 1'b0, 32'h30, 1'b0, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, 7'd12, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences and shares the 128x32 byte-maskable, pulse-triggered SRAM between two requesters: instruction fetch (read-only) and data load/store.
- Accepts byte-addressed requests over valid/ready, performs address and alignment checks, and drives the SRAM with single-cycle read/write pulses under correct setup and capture timing.
- Returns one response per accepted request at a fixed latency.
- Sits between the core's fetch and LSU stages and the SRAM macro.

Parameters:
- ADDR_W, 7, SRAM word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, word width; byte count = DATA_W/8.
- BASE_ADDR, 32'h0000_0000, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req_valid  in  1  fetch request valid.
- if_req_ready  out  1  fetch request accepted this cycle when valid.
- if_req_addr  in  32  fetch byte address.
- if_rsp_valid  out  1  fetch response, one-cycle pulse.
- if_rsp_rdata  out  32  fetch read data.
- if_rsp_err  out  1  fetch address fault.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data request accepted.
- d_req_addr  in  32  data byte address.
- d_req_we  in  1  1 = write, 0 = read.
- d_req_wmask  in  4  byte write enables; bit i enables bits [8i+7:8i].
- d_req_wdata  in  32  write data.
- d_rsp_valid  out  1  data response, one-cycle pulse.
- d_rsp_rdata  out  32  data read data; 0 for writes and errors.
- d_rsp_err  out  1  data address fault.
- sram_addr_sel  out  ADDR_W  SRAM word address.
- sram_byte_sel  out  4  SRAM byte enables.
- sram_read_pulse  out  1  SRAM read strobe.
- sram_write_pulse  out  1  SRAM write strobe.
- sram_datain  out  32  SRAM write data.
- sram_dataout  in  32  SRAM read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): FSM = IDLE.
  - All outputs 0, including both ready signals, both response valids, rdata and err, both SRAM pulses, sram_addr_sel, sram_byte_sel and sram_datain.
  - last_grant = FETCH.
- FSM states: IDLE -> SETUP -> PULSE -> RESP -> IDLE. One request in flight at a time; no pipelining.
- IDLE
  - Grant is combinational: if one port is valid, that port is granted.
  - If both ports are valid, round-robin: the port not in last_grant wins. After reset, data wins first.
  - The granted port's ready is high; the other port's ready is low. Both readies are 0 outside IDLE.
- Accept (valid && ready)
  - Latch port id, word index = (addr - BASE_ADDR) >> 2, we, wmask, wdata.
  - Update last_grant.
  - Go to SETUP.
- Error check at accept: fault if addr[1:0] != 0, or addr < BASE_ADDR, or word index >= 2**ADDR_W.
  - Faulted requests traverse all states with no SRAM pulse.
- SETUP: drive sram_addr_sel, sram_byte_sel (4'b1111 for reads, wmask for writes) and sram_datain. No pulse.
- PULSE: assert exactly one pulse for one cycle: read_pulse for reads, write_pulse for writes. Address, byte enables and data are held stable.
  - No pulse if the request faulted, or if it is a write with wmask == 4'b0000. A zero-mask write is not a fault.
- RESP
  - For reads, capture sram_dataout into the selected port's rdata.
  - Pulse the selected port's rsp_valid for one cycle. err reflects the fault flag; rdata = 0 on error or write.
  - Return to IDLE.
- Latency: accept in cycle N; rsp_valid in cycle N+3. Next accept is possible no earlier than cycle N+4.
- No response backpressure: a requester must sample the response in the cycle it is valid.
- SRAM address, byte enables and data hold their last values while IDLE. Pulses are never asserted in IDLE.
- Reset mid-operation: the in-flight request is dropped with no response; any pulse deasserts immediately.
- Address arithmetic is 32-bit unsigned. Word index is taken from bits [ADDR_W+1:2] of the offset after the range check.

Decomposition:
- Shared package sram_pkg holds:
  - state enum {IDLE, SETUP, PULSE, RESP};
  - port id enum {PORT_FETCH, PORT_DATA};
  - SRAM_ADDR_W = 7, SRAM_DEPTH = 128, BYTES_PER_WORD = 4;
  - a request struct {addr, we, wmask, wdata}.
- One natural sub-module: sram_rr_arbiter, a 2-way round-robin grant with a last_grant register.

Test Plan:
- Fetch read at 32'h10 with SRAM word 4 = 32'hDEADBEEF.
  - Ready is seen in cycle N; if_rsp_valid in N+3 with rdata 32'hDEADBEEF and err 0.
  - Exactly one read_pulse, with sram_addr_sel = 4.
- Data write at 32'h2C, wdata 32'hFACEB00C, wmask 4'b0011, over word 11 = 32'h00000000.
  - write_pulse with byte_sel 4'b0011.
  - A subsequent read of 32'h2C returns 32'h0000B00C.
- Both ports valid in the same cycle right after reset.
  - Data is granted first, fetch second.
  - Responses arrive 4 cycles apart.
  - Two further simultaneous requests alternate grants.
- Fault cases: data read at 32'h201 (misaligned) and fetch at 32'h200 (out of range).
  - Each gets rsp_valid at N+3 with err 1 and rdata 0.
  - No SRAM pulse.
- Write with wmask 4'b0000: d_rsp_valid at N+3, err 0, no write_pulse.
- rst_n asserted during the PULSE state.
  - Pulse drops asynchronously; no response is issued.
  - After release, both ready signals are 0 until a valid arrives, and a new request completes normally.
